// File: rtl/sfr_pkg.sv
// Shared definitions for the special function register file.
//   - SFR address map (SREG, SPL, SPH, five general registers)
//   - address width
//   - SREG bit positions, for the ALU and anything decoding flags
package sfr_pkg;

    localparam int SFR_ADDR_W = 3;

    localparam logic [SFR_ADDR_W-1:0] SFR_SREG = 3'd0;
    localparam logic [SFR_ADDR_W-1:0] SFR_SPL  = 3'd1;
    localparam logic [SFR_ADDR_W-1:0] SFR_SPH  = 3'd2;
    localparam logic [SFR_ADDR_W-1:0] SFR_GEN0 = 3'd3;
    localparam logic [SFR_ADDR_W-1:0] SFR_GEN1 = 3'd4;
    localparam logic [SFR_ADDR_W-1:0] SFR_GEN2 = 3'd5;
    localparam logic [SFR_ADDR_W-1:0] SFR_GEN3 = 3'd6;
    localparam logic [SFR_ADDR_W-1:0] SFR_GEN4 = 3'd7;

    localparam int SFR_NUM_GEN = 5;

    // SREG bit indices
    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;
    localparam int SREG_S = 4;
    localparam int SREG_H = 5;
    localparam int SREG_T = 6;
    localparam int SREG_I = 7;

endpackage

// File: rtl/sfr_if.sv
// Bus between the memory stage / ALU and the SFR file.
//   master: drives writes, reads, flag updates and SP steps
//   slave : the register file, returns read data, SREG, SP and wrap pulse
interface sfr_if;
    import sfr_pkg::*;

    logic                  wr_en;
    logic [SFR_ADDR_W-1:0] wr_addr;
    logic [7:0]            wr_data;
    logic [SFR_ADDR_W-1:0] rd_addr;
    logic [7:0]            rd_data;
    logic                  flag_we;
    logic [7:0]            flag_mask;
    logic [7:0]            flag_in;
    logic                  sp_inc;
    logic                  sp_dec;
    logic [7:0]            sreg_out;
    logic [15:0]           sp_out;
    logic                  sp_wrap;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, flag_we, flag_mask, flag_in,
               sp_inc, sp_dec,
        input  rd_data, sreg_out, sp_out, sp_wrap
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, flag_we, flag_mask, flag_in,
               sp_inc, sp_dec,
        output rd_data, sreg_out, sp_out, sp_wrap
    );

endinterface

// File: rtl/sfr_sp_unit.sv
// 16-bit stack pointer with byte loads, push/pop stepping and wrap detect.
//   clock, reset     : clock and synchronous active-high reset
//   load_lo, load_hi : load SPL / SPH from load_data (take priority over steps)
//   inc, dec         : pop / push step; both together means hold
//   sp               : current stack pointer
//   wrap             : registered pulse, high the cycle after a step wrapped
module sfr_sp_unit #(
    parameter logic [15:0] SP_RESET = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [7:0]  load_data,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] sp,
    output logic        wrap
);

    logic [15:0] sp_reg, sp_next;
    logic        wrap_reg, wrap_next;

    always_comb begin
        sp_next   = sp_reg;
        wrap_next = 1'b0;
        if (load_lo || load_hi) begin
            // explicit byte write suppresses any step this cycle
            if (load_lo) sp_next[7:0]  = load_data;
            if (load_hi) sp_next[15:8] = load_data;
        end else if (inc && !dec) begin
            sp_next   = sp_reg + 16'd1;
            wrap_next = (sp_reg == 16'hFFFF);
        end else if (dec && !inc) begin
            sp_next   = sp_reg - 16'd1;
            wrap_next = (sp_reg == 16'h0000);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_reg   <= SP_RESET;
            wrap_reg <= 1'b0;
        end else begin
            sp_reg   <= sp_next;
            wrap_reg <= wrap_next;
        end
    end

    assign sp   = sp_reg;
    assign wrap = wrap_reg;

endmodule

// File: rtl/sfr_file.sv
// Special function register file in the memory stage.
// Holds SREG, the stack pointer (SPH:SPL) and five general SFRs.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : byte writes, registered reads (1-cycle latency, no
//                  write-through), masked flag updates, SP push/pop,
//                  continuous SREG/SP outputs and the SP wrap pulse
module sfr_file
    import sfr_pkg::*;
#(
    parameter logic [15:0] SP_RESET   = 16'hFFFF,
    parameter logic [7:0]  SREG_RESET = 8'h00,
    parameter logic [7:0]  GEN_RESET  = 8'h00
) (
    input  logic  clock,
    input  logic  reset,
    sfr_if.slave  bus
);

    logic [7:0]                  sreg_reg, sreg_next;
    logic [7:0]                  rd_data_reg, rd_data_next;
    logic [SFR_NUM_GEN-1:0][7:0] gen_q;
    logic [15:0]                 sp;
    logic                        sp_wrap;

    // SREG: explicit write beats the ALU flag update entirely
    always_comb begin
        sreg_next = sreg_reg;
        if (bus.wr_en && bus.wr_addr == SFR_SREG) begin
            sreg_next = bus.wr_data;
        end else if (bus.flag_we) begin
            sreg_next = (sreg_reg & ~bus.flag_mask) | (bus.flag_in & bus.flag_mask);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sreg_reg <= SREG_RESET;
        end else begin
            sreg_reg <= sreg_next;
        end
    end

    sfr_sp_unit #(
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clock     (clock),
        .reset     (reset),
        .load_lo   (bus.wr_en && bus.wr_addr == SFR_SPL),
        .load_hi   (bus.wr_en && bus.wr_addr == SFR_SPH),
        .load_data (bus.wr_data),
        .inc       (bus.sp_inc),
        .dec       (bus.sp_dec),
        .sp        (sp),
        .wrap      (sp_wrap)
    );

    // general registers live at SFR_GEN0 .. SFR_GEN0+4
    generate
        for (genvar gi = 0; gi < SFR_NUM_GEN; gi++) begin : g_gen
            localparam logic [SFR_ADDR_W-1:0] ADDR = SFR_ADDR_W'(int'(SFR_GEN0) + gi);
            logic [7:0] q_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    q_reg <= GEN_RESET;
                end else if (bus.wr_en && bus.wr_addr == ADDR) begin
                    q_reg <= bus.wr_data;
                end
            end

            assign gen_q[gi] = q_reg;
        end
    endgenerate

    // read mux sees pre-edge state, so a same-cycle write is not bypassed
    always_comb begin
        rd_data_next = 8'h00;
        case (bus.rd_addr)
            SFR_SREG: rd_data_next = sreg_reg;
            SFR_SPL:  rd_data_next = sp[7:0];
            SFR_SPH:  rd_data_next = sp[15:8];
            SFR_GEN0: rd_data_next = gen_q[0];
            SFR_GEN1: rd_data_next = gen_q[1];
            SFR_GEN2: rd_data_next = gen_q[2];
            SFR_GEN3: rd_data_next = gen_q[3];
            SFR_GEN4: rd_data_next = gen_q[4];
            default:  rd_data_next = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_reg <= 8'h00;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.sreg_out = sreg_reg;
    assign bus.sp_out   = sp;
    assign bus.sp_wrap  = sp_wrap;

endmodule

// File: tb/tb_sfr_file.sv
// Self-checking bench for sfr_file: directed steps followed by a random
// phase, every cycle compared against a byte-array reference model.
module tb_sfr_file;
    import sfr_pkg::*;

    localparam logic [15:0] SP_RST   = 16'hFFFF;
    localparam logic [7:0]  SREG_RST = 8'h00;
    localparam logic [7:0]  GEN_RST  = 8'h00;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    sfr_if bus ();

    sfr_file #(
        .SP_RESET   (SP_RST),
        .SREG_RESET (SREG_RST),
        .GEN_RESET  (GEN_RST)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // reference model: the eight addressable bytes plus read/wrap outputs
    logic [7:0] m_mem [8];
    logic [7:0] m_rd;
    logic       m_wrap;

    function automatic int model_sp();
        return int'({m_mem[2], m_mem[1]});
    endfunction

    task automatic model_reset();
        m_mem[0] = SREG_RST;
        m_mem[1] = SP_RST[7:0];
        m_mem[2] = SP_RST[15:8];
        for (int i = 3; i < 8; i++) m_mem[i] = GEN_RST;
        m_rd   = 8'h00;
        m_wrap = 1'b0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive, advance model, compare every output
    task automatic cycle(input logic rst, input logic we, input logic [2:0] wa,
                         input logic [7:0] wd, input logic [2:0] ra,
                         input logic fwe, input logic [7:0] fm, input logic [7:0] fi,
                         input logic inc, input logic dec);
        int sp_now;
        int sp_new;
        reset         = rst;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.rd_addr   = ra;
        bus.flag_we   = fwe;
        bus.flag_mask = fm;
        bus.flag_in   = fi;
        bus.sp_inc    = inc;
        bus.sp_dec    = dec;
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            m_rd   = m_mem[ra];
            m_wrap = 1'b0;
            sp_now = model_sp();
            if (we) m_mem[wa] = wd;
            if (!(we && wa == 3'd0) && fwe)
                m_mem[0] = (m_mem[0] & ~fm) | (fi & fm);
            if (!(we && (wa == 3'd1 || wa == 3'd2)) && (inc != dec)) begin
                sp_new = inc ? sp_now + 1 : sp_now - 1;
                m_wrap = (sp_new > 65535) || (sp_new < 0);
                sp_new = (sp_new + 65536) % 65536;
                m_mem[1] = sp_new[7:0];
                m_mem[2] = sp_new[15:8];
            end
        end
        #1;
        check("sreg_out", {8'h00, bus.sreg_out}, {8'h00, m_mem[0]});
        check("sp_out",   bus.sp_out, {m_mem[2], m_mem[1]});
        check("sp_wrap",  {15'h0, bus.sp_wrap}, {15'h0, m_wrap});
        check("rd_data",  {8'h00, bus.rd_data}, {8'h00, m_rd});
    endtask

    task automatic idle(input logic [2:0] ra);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, ra, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] wa, input logic [7:0] wd);
        cycle(1'b0, 1'b1, wa, wd, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // reset, then read back addresses 0..3
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rst_sp", bus.sp_out, 16'hFFFF);
        idle(3'd0); check("rd_sreg_rst", {8'h0, bus.rd_data}, 16'h0000);
        idle(3'd1); check("rd_spl_rst",  {8'h0, bus.rd_data}, 16'h00FF);
        idle(3'd2); check("rd_sph_rst",  {8'h0, bus.rd_data}, 16'h00FF);
        idle(3'd3); check("rd_gen0_rst", {8'h0, bus.rd_data}, 16'h0000);

        // masked flag update, then explicit write beating flag_we
        wr(3'd0, 8'hA5);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b1, 8'h0F, 8'h3C, 1'b0, 1'b0);
        check("sreg_masked", {8'h0, bus.sreg_out}, 16'h00AC);
        cycle(1'b0, 1'b1, 3'd0, 8'h11, 3'd0, 1'b1, 8'hFF, 8'hEE, 1'b0, 1'b0);
        check("sreg_wr_wins", {8'h0, bus.sreg_out}, 16'h0011);

        // push/pop across zero
        wr(3'd1, 8'h01);
        wr(3'd2, 8'h00);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("dec1_sp", bus.sp_out, 16'h0000);
        check("dec1_wrap", {15'h0, bus.sp_wrap}, 16'h0000);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("dec2_sp", bus.sp_out, 16'hFFFF);
        check("dec2_wrap", {15'h0, bus.sp_wrap}, 16'h0001);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("inc_sp", bus.sp_out, 16'h0000);
        check("inc_wrap", {15'h0, bus.sp_wrap}, 16'h0001);
        idle(3'd0);
        check("wrap_clear", {15'h0, bus.sp_wrap}, 16'h0000);

        // conflicting SP controls
        wr(3'd1, 8'h34);
        wr(3'd2, 8'h12);
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("incdec_hold", bus.sp_out, 16'h1234);
        cycle(1'b0, 1'b1, 3'd2, 8'h56, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("wr_beats_dec", bus.sp_out, 16'h5634);
        check("wr_beats_dec_wrap", {15'h0, bus.sp_wrap}, 16'h0000);

        // read returns pre-write value
        cycle(1'b0, 1'b1, 3'd5, 8'h9A, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("rd_old", {8'h0, bus.rd_data}, 16'h0000);
        idle(3'd5);
        check("rd_new", {8'h0, bus.rd_data}, 16'h009A);

        // reset overrides simultaneous strobes
        cycle(1'b1, 1'b1, 3'd1, 8'h77, 3'd5, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        check("rst_mid_sp", bus.sp_out, 16'hFFFF);
        check("rst_mid_sreg", {8'h0, bus.sreg_out}, 16'h0000);
        idle(3'd5);
        check("rst_mid_gen2", {8'h0, bus.rd_data}, 16'h0000);

        // random phase
        for (int n = 0; n < 600; n++) begin
            logic       r_rst;
            logic       r_we;
            logic [2:0] r_wa;
            logic [7:0] r_wd;
            r_rst = ($urandom_range(0, 49) == 0);
            r_we  = ($urandom_range(0, 3) == 0);
            r_wa  = 3'($urandom_range(0, 7));
            r_wd  = 8'($urandom);
            // steer SP near its ends so wraps actually happen
            if (r_we && (r_wa == 3'd1 || r_wa == 3'd2) && $urandom_range(0, 1) == 1)
                r_wd = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            cycle(r_rst, r_we, r_wa, r_wd, 3'($urandom_range(0, 7)),
                  1'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
